// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two FIFO. Queued characters leave on tx as
// back-to-back frames: start, LSB-first data, optional parity, one or two stop bits.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_BITS-1:0]        data_in,
   input  logic                        wr_en,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic                        tx,
   output logic                        busy,
   output logic [2:0]                  state_dbg
);
   localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
   localparam int STOP_TICKS = STOP_BITS * BIT_TICKS;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(STOP_TICKS + 1);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_TICKS - 1);
   localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count_n;
   logic                 accept, pop;
   logic [DATA_BITS-1:0] head;

   state_t               state, state_n;
   logic [TW-1:0]        tick, tick_n;
   logic [BW-1:0]        bit_idx, bit_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 par_bit, par_n;
   logic                 tx_n;

   // Write handshake: data_in is taken on any edge where wr_en=1 and full=0.
   // wr_en=1 with full=1 drops the character and raises overflow for the next cycle.
   assign accept = wr_en && !full;
   assign head   = mem[rd_ptr];

   always_comb begin
      count_n = fifo_count;
      if (accept && !pop)
         count_n = fifo_count + CW'(1);
      else if (!accept && pop)
         count_n = fifo_count - CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         full       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= count_n;
         full       <= (count_n == CW'(FIFO_DEPTH));
         overflow   <= wr_en && full;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         tick    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         tx      <= 1'b1;
      end else begin
         state   <= state_n;
         tick    <= tick_n;
         bit_idx <= bit_n;
         shreg   <= shreg_n;
         par_bit <= par_n;
         tx      <= tx_n;
      end
   end

   // tx is registered: each branch drives the level of the bit that starts on this edge.
   always_comb begin
      state_n = state;
      tick_n  = tick;
      bit_n   = bit_idx;
      shreg_n = shreg;
      par_n   = par_bit;
      tx_n    = tx;
      pop     = 1'b0;
      case (state)
         S_IDLE: pop = (fifo_count != '0);
         S_START: begin
            if (tick == BIT_LAST) begin
               tick_n  = '0;
               bit_n   = '0;
               tx_n    = shreg[0];
               state_n = S_DATA;
            end else begin
               tick_n = tick + TW'(1);
            end
         end
         S_DATA: begin
            if (tick == BIT_LAST) begin
               tick_n = '0;
               if (bit_idx == DATA_LAST) begin
                  if (PARITY != 0) begin
                     tx_n    = par_bit;
                     state_n = S_PARITY;
                  end else begin
                     tx_n    = 1'b1;
                     state_n = S_STOP;
                  end
               end else begin
                  bit_n   = bit_idx + BW'(1);
                  shreg_n = shreg >> 1;
                  tx_n    = shreg[1];
               end
            end else begin
               tick_n = tick + TW'(1);
            end
         end
         S_PARITY: begin
            if (tick == BIT_LAST) begin
               tick_n  = '0;
               tx_n    = 1'b1;
               state_n = S_STOP;
            end else begin
               tick_n = tick + TW'(1);
            end
         end
         S_STOP: begin
            if (tick == STOP_LAST) begin
               tick_n  = '0;
               state_n = S_IDLE;
               pop     = (fifo_count != '0);
            end else begin
               tick_n = tick + TW'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase
      // Parity is latched from the popped character so later writes cannot disturb it.
      if (pop) begin
         shreg_n = head;
         par_n   = (PARITY == 1) ? ~(^head) : ^head;
         tx_n    = 1'b0;
         tick_n  = '0;
         state_n = S_START;
      end
   end

   assign busy      = (state != S_IDLE) || (fifo_count != '0);
   assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: an 8N1 depth-4 instance checked by a UART receiver and an
// expected-character queue, plus 7E2 and 7O2 instances checked bit by bit.
module tb_uart_tx_fifo;
   localparam int CLK_HZ = 1000000;
   localparam int BAUD   = 100000;
   localparam int BT     = 10;
   localparam int DEPTH  = 4;
   localparam int FRAME0 = 10 * BT;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data0 = '0;
   logic       wr0 = 1'b0;
   logic       full0, ovf0, tx0, busy0;
   logic [2:0] cnt0, st0;
   logic [6:0] data1 = '0;
   logic       wr1 = 1'b0;
   logic       full1, ovf1, tx1, busy1;
   logic [2:0] cnt1, st1;
   logic       full2, ovf2, tx2, busy2;
   logic [2:0] cnt2, st2;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_fifo #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
      .clk(clk), .reset(reset), .data_in(data0), .wr_en(wr0), .full(full0),
      .fifo_count(cnt0), .overflow(ovf0), .tx(tx0), .busy(busy0), .state_dbg(st0));

   uart_tx_fifo #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut1 (
      .clk(clk), .reset(reset), .data_in(data1), .wr_en(wr1), .full(full1),
      .fifo_count(cnt1), .overflow(ovf1), .tx(tx1), .busy(busy1), .state_dbg(st1));

   uart_tx_fifo #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut2 (
      .clk(clk), .reset(reset), .data_in(data1), .wr_en(wr1), .full(full2),
      .fifo_count(cnt2), .overflow(ovf2), .tx(tx2), .busy(busy2), .state_dbg(st2));

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected line level of bit slot idx (0 = start) for a frame carrying d.
   function automatic logic line_bit(input logic [8:0] d, input int nbits, input int par,
                                     input int idx);
      logic x;
      x = 1'b0;
      for (int i = 0; i < nbits; i++) x ^= d[i];
      if (idx == 0) return 1'b0;
      if (idx <= nbits) return d[idx-1];
      if (par != 0 && idx == nbits + 1) return (par == 2) ? x : ~x;
      return 1'b1;
   endfunction

   // lead = cycles of the start bit already elapsed when called (0: wait for it).
   task automatic rx0(input int lead, output logic [7:0] d, output bit ok, output int t0);
      int n;
      n  = 0;
      ok = 1'b1;
      d  = '0;
      while (lead == 0 && tx0 !== 1'b0 && n < 3000) begin
         step(1);
         n++;
      end
      t0 = cyc - lead;
      if (tx0 !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      step(BT/2 - lead);
      if (tx0 !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(BT);
         d[i] = tx0;
      end
      step(BT);
      if (tx0 !== 1'b1) ok = 1'b0;
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      step(3);
      total++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || full0 !== 1'b0 || cnt0 !== 3'd0 || ovf0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_vals tx=%b busy=%b full=%b cnt=%0d ovf=%b want 1 0 0 0 0",
                  tx0, busy0, full0, cnt0, ovf0);
      end
      total++;
      if (st0 !== 3'd0 || tx1 !== 1'b1 || tx2 !== 1'b1) begin
         bad++;
         $display("FAIL reset_state st=%0d tx1=%b tx2=%b want 0 1 1", st0, tx1, tx2);
      end
      reset = 1'b0;
      step(2);
      total++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle tx=%b busy=%b want 1 0", tx0, busy0);
      end
   endtask

   task automatic test_8n1;
      logic e;
      int   err;
      data0 = 8'h55;
      wr0   = 1'b1;
      step(1);
      wr0 = 1'b0;
      total++;
      if (cnt0 !== 3'd1 || busy0 !== 1'b1 || tx0 !== 1'b1) begin
         bad++;
         $display("FAIL accept cnt=%0d busy=%b tx=%b want 1 1 1", cnt0, busy0, tx0);
      end
      step(1);
      total++;
      if (tx0 !== 1'b0 || cnt0 !== 3'd0) begin
         bad++;
         $display("FAIL start_latency tx=%b cnt=%0d want 0 0", tx0, cnt0);
      end
      for (int b = 0; b < 10; b++) begin
         e   = line_bit({1'b0, 8'h55}, 8, 0, b);
         err = 0;
         for (int c = 0; c < BT; c++) begin
            if (tx0 !== e || busy0 !== 1'b1) err++;
            step(1);
         end
         total++;
         if (err != 0) begin
            bad++;
            $display("FAIL 8n1_bit%0d errors=%0d want tx=%b busy=1 for %0d cycles", b, err, e, BT);
         end
      end
      total++;
      if (busy0 !== 1'b0 || tx0 !== 1'b1) begin
         bad++;
         $display("FAIL busy_drop busy=%b tx=%b want 0 1", busy0, tx0);
      end
   endtask

   task automatic test_parity;
      logic [6:0] vals [2];
      logic       e1, e2;
      int         err1, err2;
      vals[0] = 7'h03;
      vals[1] = 7'h07;
      for (int v = 0; v < 2; v++) begin
         data1 = vals[v];
         wr1   = 1'b1;
         step(1);
         wr1 = 1'b0;
         step(1);
         for (int b = 0; b < 11; b++) begin
            e1   = line_bit({2'b0, vals[v]}, 7, 2, b);
            e2   = line_bit({2'b0, vals[v]}, 7, 1, b);
            err1 = 0;
            err2 = 0;
            for (int c = 0; c < BT; c++) begin
               if (tx1 !== e1) err1++;
               if (tx2 !== e2) err2++;
               step(1);
            end
            total++;
            if (err1 != 0) begin
               bad++;
               $display("FAIL even_v%0d_bit%0d errors=%0d want tx=%b", v, b, err1, e1);
            end
            total++;
            if (err2 != 0) begin
               bad++;
               $display("FAIL odd_v%0d_bit%0d errors=%0d want tx=%b", v, b, err2, e2);
            end
         end
         total++;
         if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL parity_frame_len v%0d busy1=%b busy2=%b want 0 0 after 110", v, busy1, busy2);
         end
         step(3);
      end
   endtask

   task automatic test_fifo_full;
      logic [7:0] got, exp;
      bit         ok;
      int         t0, first;
      first = 0;
      for (int i = 0; i < 5; i++) begin
         data0 = 8'h41 + 8'(i);
         wr0   = 1'b1;
         exp_q.push_back(8'h41 + 8'(i));
         step(1);
      end
      total++;
      if (cnt0 !== 3'd4 || full0 !== 1'b1 || ovf0 !== 1'b0) begin
         bad++;
         $display("FAIL fill cnt=%0d full=%b ovf=%b want 4 1 0", cnt0, full0, ovf0);
      end
      data0 = 8'h46;
      step(1);
      wr0 = 1'b0;
      total++;
      if (ovf0 !== 1'b1 || cnt0 !== 3'd4) begin
         bad++;
         $display("FAIL overflow ovf=%b cnt=%0d want 1 4", ovf0, cnt0);
      end
      step(1);
      total++;
      if (ovf0 !== 1'b0) begin
         bad++;
         $display("FAIL overflow_pulse ovf=%b want 0", ovf0);
      end
      for (int k = 0; k < 5; k++) begin
         rx0((k == 0) ? 5 : 0, got, ok, t0);
         if (k == 0) first = t0;
         exp = 8'hxx;
         if (exp_q.size() != 0) exp = exp_q.pop_front();
         total++;
         if (!ok || got !== exp) begin
            bad++;
            $display("FAIL full_frame%0d got=%02h ok=%0d want %02h", k, got, ok, exp);
         end
         if (k > 0) begin
            total++;
            if (t0 != first + FRAME0 * k) begin
               bad++;
               $display("FAIL gap_frame%0d start=%0d want %0d", k, t0, first + FRAME0 * k);
            end
         end
      end
      step(10);
      total++;
      if (busy0 !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL full_drain busy=%b left=%0d want 0 0", busy0, exp_q.size());
      end
   endtask

   task automatic test_full_pop;
      logic [7:0] got, exp;
      bit         ok;
      int         t0, first;
      first = 0;
      for (int i = 0; i < 5; i++) begin
         data0 = 8'h61 + 8'(i);
         wr0   = 1'b1;
         exp_q.push_back(8'h61 + 8'(i));
         step(1);
      end
      wr0 = 1'b0;
      rx0(3, got, ok, first);
      exp = exp_q.pop_front();
      total++;
      if (!ok || got !== exp) begin
         bad++;
         $display("FAIL pop_frame0 got=%02h ok=%0d want %02h", got, ok, exp);
      end
      step(4);
      data0 = 8'h99;
      wr0   = 1'b1;
      total++;
      if (full0 !== 1'b1 || cnt0 !== 3'd4) begin
         bad++;
         $display("FAIL pre_pop full=%b cnt=%0d want 1 4", full0, cnt0);
      end
      step(1);
      wr0 = 1'b0;
      total++;
      if (ovf0 !== 1'b1 || cnt0 !== 3'(DEPTH - 1) || full0 !== 1'b0 || tx0 !== 1'b0) begin
         bad++;
         $display("FAIL write_in_pop ovf=%b cnt=%0d full=%b tx=%b want 1 3 0 0", ovf0, cnt0, full0, tx0);
      end
      for (int k = 1; k < 5; k++) begin
         rx0(0, got, ok, t0);
         exp = 8'hxx;
         if (exp_q.size() != 0) exp = exp_q.pop_front();
         total++;
         if (!ok || got !== exp || t0 != first + FRAME0 * k) begin
            bad++;
            $display("FAIL pop_frame%0d got=%02h ok=%0d start=%0d want %02h at %0d",
                     k, got, ok, t0, exp, first + FRAME0 * k);
         end
      end
      step(10);
      total++;
      if (busy0 !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL pop_drain busy=%b left=%0d want 0 0", busy0, exp_q.size());
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] got, exp;
      bit         ok;
      int         t0, err;
      for (int i = 0; i < 4; i++) begin
         data0 = 8'h71 + 8'(i);
         wr0   = 1'b1;
         step(1);
      end
      wr0 = 1'b0;
      total++;
      if (cnt0 !== 3'd3) begin
         bad++;
         $display("FAIL queued3 cnt=%0d want 3", cnt0);
      end
      step(33);
      total++;
      if (tx0 !== line_bit({1'b0, 8'h71}, 8, 0, 3)) begin
         bad++;
         $display("FAIL tick35_level tx=%b want %b", tx0, line_bit({1'b0, 8'h71}, 8, 0, 3));
      end
      reset = 1'b1;
      data0 = 8'hEE;
      wr0   = 1'b1;
      #1;
      total++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 3'd0 || full0 !== 1'b0) begin
         bad++;
         $display("FAIL async_reset tx=%b busy=%b cnt=%0d full=%b want 1 0 0 0", tx0, busy0, cnt0, full0);
      end
      step(3);
      wr0   = 1'b0;
      reset = 1'b0;
      err   = 0;
      for (int c = 0; c < 300; c++) begin
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 3'd0) err++;
         step(1);
      end
      total++;
      if (err != 0) begin
         bad++;
         $display("FAIL quiet_after_reset errors=%0d want 0", err);
      end
      data0 = 8'h5A;
      wr0   = 1'b1;
      exp_q.push_back(8'h5A);
      step(1);
      wr0 = 1'b0;
      rx0(0, got, ok, t0);
      exp = exp_q.pop_front();
      total++;
      if (!ok || got !== exp) begin
         bad++;
         $display("FAIL after_reset_frame got=%02h ok=%0d want %02h", got, ok, exp);
      end
      step(10);
   endtask

   task automatic test_wrap;
      fork
         begin
            for (int i = 0; i < 2 * DEPTH; i++) begin
               logic [7:0] d;
               d = 8'($urandom_range(0, 255));
               total++;
               if (full0 !== 1'b0) begin
                  bad++;
                  $display("FAIL wrap_not_full w%0d full=%b want 0", i, full0);
               end
               data0 = d;
               wr0   = 1'b1;
               exp_q.push_back(d);
               step(1);
               wr0 = 1'b0;
               step($urandom_range(70, 110));
            end
         end
         begin
            for (int i = 0; i < 2 * DEPTH; i++) begin
               logic [7:0] got, exp;
               bit         ok;
               int         t0;
               rx0(0, got, ok, t0);
               exp = 8'hxx;
               if (exp_q.size() != 0) exp = exp_q.pop_front();
               total++;
               if (!ok || got !== exp) begin
                  bad++;
                  $display("FAIL wrap_frame%0d got=%02h ok=%0d want %02h", i, got, ok, exp);
               end
            end
         end
      join
      step(10);
      total++;
      if (busy0 !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL wrap_drain busy=%b left=%0d want 0 0", busy0, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_fifo_full();
      test_full_pop();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
